// File: rtl/dma_pkg.sv
// Shared DMA definitions: transfer FSM states and the word size.
package dma_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdWait,
        StWrReq,
        StWrWait,
        StFinish
    } dma_xfer_state_e;

    localparam int unsigned DmaWordBytes = 4;

endpackage

// File: rtl/obi_pkg.sv
// Minimal OBI configuration and channel types used by the DMA manager port.
// Fixed 32-bit address/data channels; optional OBI sideband fields are left out.
package obi_pkg;

    typedef struct packed {
        logic        UseRReady;
        int unsigned AddrWidth;
        int unsigned DataWidth;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{UseRReady: 1'b0, AddrWidth: 32, DataWidth: 32};

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_a_chan_t;

    typedef struct packed {
        obi_a_chan_t a;
        logic        req;
        logic        rready;
    } obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;

endpackage

// File: rtl/dma_xfer_ctrl_if.sv
// OBI manager bundle between the DMA copy engine and the peripheral demux DMA port.
interface dma_xfer_ctrl_if #(
    parameter type obi_req_t = obi_pkg::obi_req_t,
    parameter type obi_rsp_t = obi_pkg::obi_rsp_t
) ();

    obi_req_t dma_req;
    obi_rsp_t dma_rsp;

    modport master (output dma_req, input dma_rsp);
    modport slave  (input dma_req, output dma_rsp);

endinterface

// File: rtl/dma_xfer_ctrl.sv
// Word-by-word memory copy engine: one OBI read then one OBI write per word,
// with a single outstanding transaction at any time.
module dma_xfer_ctrl
    import dma_pkg::*;
#(
    parameter obi_pkg::obi_cfg_t ObiCfg    = obi_pkg::ObiDefaultConfig,
    parameter type               obi_req_t = obi_pkg::obi_req_t,
    parameter type               obi_rsp_t = obi_pkg::obi_rsp_t,
    parameter int unsigned       LenWidth  = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        start_i,
    input  logic                        abort_i,
    input  logic [ObiCfg.AddrWidth-1:0] src_addr_i,
    input  logic [ObiCfg.AddrWidth-1:0] dst_addr_i,
    input  logic [LenWidth-1:0]         len_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o,
    output logic [LenWidth-1:0]         words_done_o,
    output logic                        dma_active_o,
    dma_xfer_ctrl_if.master             dma_bus
);

    localparam int unsigned AddrWidth = ObiCfg.AddrWidth;

    dma_xfer_state_e       state_q, state_d;
    logic [AddrWidth-1:0]  src_q, src_d;
    logic [AddrWidth-1:0]  dst_q, dst_d;
    logic [LenWidth-1:0]   len_q, len_d;
    logic [LenWidth-1:0]   cnt_q, cnt_d;
    logic [31:0]           buf_q, buf_d;
    logic                  err_q, err_d;
    obi_req_t              req;
    obi_rsp_t              rsp;

    assign rsp             = dma_bus.dma_rsp;
    assign dma_bus.dma_req = req;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        err_d      = err_q;
        done_o     = 1'b0;
        req        = '0;
        req.rready = ObiCfg.UseRReady;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    err_d = 1'b0;
                    if (len_i != '0) begin
                        src_d   = src_addr_i;
                        dst_d   = dst_addr_i;
                        len_d   = len_i;
                        cnt_d   = '0;
                        state_d = StRdReq;
                    end else begin
                        state_d = StFinish;
                    end
                end
            end
            // A-channel is a pure function of registered state, so it holds while gnt is low.
            StRdReq: begin
                req.req    = 1'b1;
                req.a.addr = src_q;
                req.a.be   = 4'hF;
                if (rsp.gnt) state_d = StRdWait;
            end
            StRdWait: begin
                if (rsp.rvalid) begin
                    buf_d = rsp.r.rdata;
                    if (rsp.r.err) begin
                        err_d   = 1'b1;
                        state_d = StFinish;
                    end else begin
                        state_d = StWrReq;
                    end
                end
            end
            StWrReq: begin
                req.req     = 1'b1;
                req.a.we    = 1'b1;
                req.a.addr  = dst_q;
                req.a.be    = 4'hF;
                req.a.wdata = buf_q;
                if (rsp.gnt) state_d = StWrWait;
            end
            StWrWait: begin
                if (rsp.rvalid) begin
                    if (rsp.r.err) begin
                        err_d   = 1'b1;
                        state_d = StFinish;
                    end else begin
                        src_d   = src_q + AddrWidth'(DmaWordBytes);
                        dst_d   = dst_q + AddrWidth'(DmaWordBytes);
                        cnt_d   = cnt_q + LenWidth'(1);
                        state_d = ((cnt_q + LenWidth'(1)) == len_q || abort_i) ? StFinish : StRdReq;
                    end
                end
            end
            StFinish: begin
                done_o  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy_o       = (state_q != StIdle);
    assign dma_active_o = busy_o;
    assign err_o        = err_q;
    assign words_done_o = cnt_q;

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// Directed bench for dma_xfer_ctrl: an OBI slave/monitor checks every bus beat against
// an expected transaction list built from the copy rules; per-transfer results are checked too.
module tb_dma_xfer_ctrl;
    import obi_pkg::*;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xact_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [15:0] len = '0;
    logic        busy, done, err, dma_active;
    logic [15:0] words_done;

    always #5 clk_i = ~clk_i;

    dma_xfer_ctrl_if bus ();

    dma_xfer_ctrl #(.LenWidth(16)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .src_addr_i   (src_addr),
        .dst_addr_i   (dst_addr),
        .len_i        (len),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .words_done_o (words_done),
        .dma_active_o (dma_active),
        .dma_bus      (bus)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: event seen, none allowed", name);
    endtask

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Source memory content is pat(addr); writes land in wmem.
    xact_t       exp_q[$];
    xact_t       e;
    logic [31:0] wmem[logic [31:0]];
    int          stall_n = 0, err_rd_idx = 0, rd_hs = 0, wr_hs = 0, stalled = 0, pend_idx = 0;
    logic        pend = 1'b0, pend_we = 1'b0, was_pend = 1'b0, prev_wait = 1'b0;
    logic [31:0] pend_addr = '0, pend_wdata = '0;
    obi_req_t    prev_req, cur;

    task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                             input bit extra_rd);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{we: 1'b0, addr: s + 32'(4 * i), wdata: 32'h0});
            exp_q.push_back('{we: 1'b1, addr: d + 32'(4 * i), wdata: pat(s + 32'(4 * i))});
        end
        if (extra_rd) exp_q.push_back('{we: 1'b0, addr: s + 32'(4 * n), wdata: 32'h0});
    endtask

    always @(negedge clk_i) begin
        cur = bus.dma_req;
        chk("active_eq_busy", {31'b0, dma_active}, {31'b0, busy});
        chk("rready_tied", {31'b0, cur.rready}, 32'h0);
        bus.dma_rsp = '0;
        if (!rst_ni) begin
            pend      = 1'b0;
            prev_wait = 1'b0;
            chk("req_in_reset", {31'b0, cur.req}, 32'h0);
        end else begin
            was_pend = pend;
            if (pend) begin
                bus.dma_rsp.rvalid = 1'b1;
                if (pend_we) wmem[pend_addr] = pend_wdata;
                else begin
                    bus.dma_rsp.r.rdata = pat(pend_addr);
                    bus.dma_rsp.r.err   = (pend_idx == err_rd_idx);
                end
            end
            pend = 1'b0;
            if (cur.req) begin
                chk("req_while_outstanding", {31'b0, was_pend}, 32'h0);
                chk("be", {28'b0, cur.a.be}, 32'hF);
                if (prev_wait) begin
                    chk("stable_addr", cur.a.addr, prev_req.a.addr);
                    chk("stable_we", {31'b0, cur.a.we}, {31'b0, prev_req.a.we});
                    chk("stable_wdata", cur.a.wdata, prev_req.a.wdata);
                end
                if (stall_n > 0) begin
                    stall_n--;
                    stalled++;
                    prev_wait = 1'b1;
                    prev_req  = cur;
                end else begin
                    bus.dma_rsp.gnt = 1'b1;
                    prev_wait       = 1'b0;
                    if (exp_q.size() == 0) fail("unexpected_req");
                    else begin
                        e = exp_q.pop_front();
                        chk("we", {31'b0, cur.a.we}, {31'b0, e.we});
                        chk("addr", cur.a.addr, e.addr);
                        if (e.we) chk("wdata", cur.a.wdata, e.wdata);
                    end
                    if (cur.a.we) wr_hs++;
                    else rd_hs++;
                    pend       = 1'b1;
                    pend_idx   = rd_hs;
                    pend_we    = cur.a.we;
                    pend_addr  = cur.a.addr;
                    pend_wdata = cur.a.wdata;
                end
            end else begin
                if (prev_wait) fail("req_retracted");
                prev_wait = 1'b0;
            end
        end
    end

    task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                            input int abort_after, output int busy_n, output int done_at,
                            output int done_n);
        @(negedge clk_i);
        src_addr = s;
        dst_addr = d;
        len      = l;
        start_i  = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        busy_n  = 0;
        done_at = 0;
        done_n  = 0;
        for (int c = 1; c <= 400; c++) begin
            if (abort_after > 0 && rd_hs >= abort_after) abort_i = 1'b1;
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                done_at = c;
            end
            if (!busy) return;
            @(negedge clk_i);
        end
        fail("xfer_timeout");
    endtask

    int bn, da, dn;

    initial begin
        repeat (3) @(negedge clk_i);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        chk("rst_words", {16'b0, words_done}, 32'h0);
        rst_ni = 1'b1;

        // Zero-wait copy of three words: 12 working cycles plus the finish cycle.
        push_copy(32'h1000, 32'h2000, 3, 1'b0);
        run_xfer(32'h1000, 32'h2000, 16'd3, 0, bn, da, dn);
        chk("t1_words", {16'b0, words_done}, 32'd3);
        chk("t1_err", {31'b0, err}, 32'h0);
        chk("t1_busy_cycles", bn, 32'd13);
        chk("t1_done_at", da, 32'd13);
        chk("t1_done_pulses", dn, 32'd1);
        chk("t1_queue_drained", exp_q.size(), 32'd0);
        chk("t1_mem0", wmem[32'h2000], 32'hA5A5_1000);
        chk("t1_mem2", wmem[32'h2008], 32'hA5A5_1008);

        // First read grant held off for five cycles.
        stall_n = 5;
        stalled = 0;
        push_copy(32'h3000, 32'h4000, 2, 1'b0);
        run_xfer(32'h3000, 32'h4000, 16'd2, 0, bn, da, dn);
        chk("t2_stalled", stalled, 32'd5);
        chk("t2_words", {16'b0, words_done}, 32'd2);
        chk("t2_busy_cycles", bn, 32'd14);
        chk("t2_mem1", wmem[32'h4004], 32'hA5A5_3004);

        // Error response on the second read ends the transfer before its write.
        rd_hs      = 0;
        err_rd_idx = 2;
        push_copy(32'h5000, 32'h6000, 1, 1'b1);
        run_xfer(32'h5000, 32'h6000, 16'd4, 0, bn, da, dn);
        err_rd_idx = 0;
        chk("t3_err", {31'b0, err}, 32'h1);
        chk("t3_words", {16'b0, words_done}, 32'd1);
        chk("t3_done_pulses", dn, 32'd1);
        chk("t3_busy_cycles", bn, 32'd7);
        chk("t3_no_2nd_write", {31'b0, wmem.exists(32'h6004)}, 32'h0);
        chk("t3_queue_drained", exp_q.size(), 32'd0);

        // Zero length: error clears, count is kept, no bus traffic.
        run_xfer(32'h5000, 32'h6000, 16'd0, 0, bn, da, dn);
        chk("t4_err_cleared", {31'b0, err}, 32'h0);
        chk("t4_words_kept", {16'b0, words_done}, 32'd1);
        chk("t4_busy_cycles", bn, 32'd1);
        chk("t4_done_at", da, 32'd1);

        // Abort raised once the second read is granted: that word still completes.
        rd_hs = 0;
        push_copy(32'hB000, 32'hC000, 2, 1'b0);
        run_xfer(32'hB000, 32'hC000, 16'd8, 2, bn, da, dn);
        abort_i = 1'b0;
        chk("t5_words", {16'b0, words_done}, 32'd2);
        chk("t5_done_pulses", dn, 32'd1);
        chk("t5_busy_cycles", bn, 32'd9);
        chk("t5_queue_drained", exp_q.size(), 32'd0);

        // Addresses wrap past the top of the address space.
        push_copy(32'hFFFF_FFFC, 32'h0000_0100, 2, 1'b0);
        run_xfer(32'hFFFF_FFFC, 32'h0000_0100, 16'd2, 0, bn, da, dn);
        chk("t7_wrap_mem", wmem[32'h0000_0104], 32'hA5A5_0000);
        chk("t7_words", {16'b0, words_done}, 32'd2);

        // Start pulse while busy is ignored; reset lands in the second write wait.
        rd_hs = 0;
        wr_hs = 0;
        push_copy(32'h7000, 32'h8000, 2, 1'b0);
        @(negedge clk_i);
        src_addr = 32'h7000;
        dst_addr = 32'h8000;
        len      = 16'd4;
        start_i  = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int c = 0; c < 50 && rd_hs < 1; c++) @(negedge clk_i);
        src_addr = 32'h9000;
        dst_addr = 32'hA000;
        len      = 16'd1;
        start_i  = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("t6_still_busy", {31'b0, busy}, 32'h1);
        for (int c = 0; c < 50; c++) begin
            @(posedge clk_i);
            #1;
            if (wr_hs >= 2) break;
        end
        chk("t6_reached_wr_wait", wr_hs, 32'd2);
        chk("t6_words_before_rst", {16'b0, words_done}, 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_busy", {31'b0, busy}, 32'h0);
        chk("t6_rst_done", {31'b0, done}, 32'h0);
        chk("t6_rst_active", {31'b0, dma_active}, 32'h0);
        chk("t6_rst_words", {16'b0, words_done}, 32'h0);
        chk("t6_rst_req", {31'b0, bus.dma_req.req}, 32'h0);
        exp_q.delete();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("t6_idle_after_rst", {31'b0, busy}, 32'h0);
        chk("t6_err_after_rst", {31'b0, err}, 32'h0);
        chk("t6_first_write", wmem[32'h8000], 32'hA5A5_7000);
        chk("t6_ignored_start", {31'b0, wmem.exists(32'hA000)}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
